// File: rtl/uart_transmitter.sv
`timescale 1ns/1ps

// Generic synchronous FIFO with a combinational head read and an occupancy count.
// Latency: a pushed entry is visible at the head on the cycle after the push edge.
// Backpressure: none internally; the caller must gate push on full and pop on empty.
module uart_tx_fifo #(
    parameter int DEPTH = 4,
    parameter int W     = 8
) (
    input  logic                     clk,
    input  logic                     rst_n,
    input  logic                     push,
    input  logic [W-1:0]             wr_data,
    input  logic                     pop,
    output logic [W-1:0]             head,
    output logic [$clog2(DEPTH):0]   count
);
    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    logic [W-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;

    assign head = mem[rd_ptr];

    always_ff @(posedge clk) begin
        if (push) begin
            mem[wr_ptr] <= wr_data;
        end
    end

    // Power-of-two depth lets the pointers wrap by plain overflow.
    always_ff @(posedge clk) begin
        if (!rst_n) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            count  <= '0;
        end else begin
            if (push) wr_ptr <= wr_ptr + AW'(1);
            if (pop)  rd_ptr <= rd_ptr + AW'(1);
            case ({push, pop})
                2'b10:   count <= count + CW'(1);
                2'b01:   count <= count - CW'(1);
                default: count <= count;
            endcase
        end
    end
endmodule

// 8N1 (or 8N2) UART transmitter fed from a small byte FIFO, LSB first, idle-high line.
// Latency: a byte pushed into an empty FIFO while idle drops the line one cycle later.
// Backpressure: tx_ready falls while the FIFO is full; bytes offered then are dropped.
module uart_transmitter #(
    parameter int F_CLK      = 1_000_000,
    parameter int BAUDRATE   = 9600,
    parameter int FIFO_DEPTH = 4,
    parameter int STOP_BITS  = 1
) (
    input  logic                          clk,
    input  logic                          rst_n,
    input  logic [7:0]                    tx_data,
    input  logic                          tx_valid,
    output logic                          tx_ready,
    output logic                          tx,
    output logic                          tx_busy,
    output logic [$clog2(FIFO_DEPTH):0]   fifo_count
);
    localparam int CLKS_PER_BIT = F_CLK / BAUDRATE;
    localparam int STOP_CLKS    = STOP_BITS * CLKS_PER_BIT;
    localparam int CNT_W        = $clog2(STOP_CLKS);
    localparam int FC_W         = $clog2(FIFO_DEPTH) + 1;

    localparam logic [CNT_W-1:0] BIT_LAST  = CNT_W'(CLKS_PER_BIT - 1);
    localparam logic [CNT_W-1:0] STOP_LAST = CNT_W'(STOP_CLKS - 1);

    typedef enum logic [1:0] {IDLE, START, DATA, STOP} state_t;

    state_t           state;
    logic [CNT_W-1:0] clk_cnt;
    logic [2:0]       bit_idx;
    logic [7:0]       shift;
    logic [7:0]       head;
    logic             push;
    logic             pop;
    logic             has_data;
    logic             stop_done;

    assign tx_ready  = (fifo_count != FC_W'(FIFO_DEPTH));
    assign push      = tx_valid && tx_ready;
    assign has_data  = (fifo_count != '0);
    assign stop_done = (state == STOP) && (clk_cnt == STOP_LAST);
    // The next frame is fetched either from idle or on the last stop cycle, so frames abut.
    assign pop       = has_data && ((state == IDLE) || stop_done);

    uart_tx_fifo #(
        .DEPTH (FIFO_DEPTH),
        .W     (8)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .push    (push),
        .wr_data (tx_data),
        .pop     (pop),
        .head    (head),
        .count   (fifo_count)
    );

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state   <= IDLE;
            tx      <= 1'b1;
            tx_busy <= 1'b0;
            clk_cnt <= '0;
            bit_idx <= '0;
            shift   <= '0;
        end else begin
            case (state)
                IDLE: begin
                    clk_cnt <= '0;
                    bit_idx <= '0;
                    if (has_data) begin
                        shift   <= head;
                        tx      <= 1'b0;
                        tx_busy <= 1'b1;
                        state   <= START;
                    end else begin
                        tx      <= 1'b1;
                        tx_busy <= 1'b0;
                    end
                end
                START: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        tx      <= shift[0];
                        state   <= DATA;
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                DATA: begin
                    if (clk_cnt == BIT_LAST) begin
                        clk_cnt <= '0;
                        if (bit_idx == 3'd7) begin
                            tx    <= 1'b1;
                            state <= STOP;
                        end else begin
                            shift   <= {1'b0, shift[7:1]};
                            tx      <= shift[1];
                            bit_idx <= bit_idx + 3'd1;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                STOP: begin
                    if (stop_done) begin
                        clk_cnt <= '0;
                        bit_idx <= '0;
                        if (has_data) begin
                            shift <= head;
                            tx    <= 1'b0;
                            state <= START;
                        end else begin
                            tx_busy <= 1'b0;
                            state   <= IDLE;
                        end
                    end else begin
                        clk_cnt <= clk_cnt + CNT_W'(1);
                    end
                end
                default: begin
                    state   <= IDLE;
                    tx      <= 1'b1;
                    tx_busy <= 1'b0;
                end
            endcase
        end
    end
endmodule

// File: tb/tb_uart_transmitter.sv
`timescale 1ns/1ps

// Bench for uart_transmitter: two instances (one and two stop bits) against a frame-level model.
module tb_uart_transmitter;
    localparam int CPB = 8;

    logic       clk;
    logic       rst_n;
    logic [7:0] dat0, dat1;
    logic       v0, v1;
    logic       ready0, ready1, tx0, tx1, busy0, busy1;
    logic [2:0] count0, count1;

    uart_transmitter #(.F_CLK(8), .BAUDRATE(1), .FIFO_DEPTH(4), .STOP_BITS(1)) dut0 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat0), .tx_valid(v0), .tx_ready(ready0),
        .tx(tx0), .tx_busy(busy0), .fifo_count(count0)
    );

    uart_transmitter #(.F_CLK(8), .BAUDRATE(1), .FIFO_DEPTH(4), .STOP_BITS(2)) dut1 (
        .clk(clk), .rst_n(rst_n), .tx_data(dat1), .tx_valid(v1), .tx_ready(ready1),
        .tx(tx1), .tx_busy(busy1), .fifo_count(count1)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;
    int cyc    = 0;

    // Frame-level model: queued bytes, the byte on the line and the edge its start bit began.
    logic [7:0] mf [2][4];
    int         msize [2];
    logic       mbusy [2];
    int         ms [2];
    logic [7:0] mcur [2];
    int         frame_len [2];
    logic [7:0] sent_q [$];

    // Line receiver watching dut0, sampling mid-bit.
    logic [7:0] rx_q [$];
    logic       rx_on;
    int         rx_t;
    logic [7:0] rx_b;

    logic [9:0] a5_line;
    int n, s, bc, base_sent;
    logic saw_full, q_ok, idle_ok;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    function automatic logic exp_tx(input int d);
        int k;
        if (!mbusy[d]) return 1'b1;
        k = (cyc - ms[d]) / CPB;
        if (k == 0) return 1'b0;
        if (k <= 8) return mcur[d][k-1];
        return 1'b1;
    endfunction

    task automatic model_edge(input int d, input logic v, input logic [7:0] dat);
        int pre;
        logic acc;
        if (!rst_n) begin
            msize[d] = 0;
            mbusy[d] = 1'b0;
            return;
        end
        pre = msize[d];
        acc = v && (pre != 4);
        if (mbusy[d] && (cyc - ms[d] == frame_len[d])) begin
            mbusy[d] = 1'b0;
            if (d == 0) sent_q.push_back(mcur[d]);
        end
        if (!mbusy[d] && pre != 0) begin
            mcur[d] = mf[d][0];
            for (int i = 0; i < 3; i++) mf[d][i] = mf[d][i+1];
            msize[d]--;
            mbusy[d] = 1'b1;
            ms[d] = cyc;
        end
        if (acc) begin
            mf[d][msize[d]] = dat;
            msize[d]++;
        end
    endtask

    task automatic cmp_dut(input int d, input logic t, input logic b, input logic r, input logic [2:0] c);
        chk($sformatf("d%0d_tx@%0d", d, cyc), {31'b0, t}, {31'b0, exp_tx(d)});
        chk($sformatf("d%0d_busy@%0d", d, cyc), {31'b0, b}, {31'b0, mbusy[d]});
        chk($sformatf("d%0d_ready@%0d", d, cyc), {31'b0, r}, {31'b0, msize[d] != 4});
        chk($sformatf("d%0d_count@%0d", d, cyc), {29'b0, c}, {29'b0, 3'(msize[d])});
    endtask

    task automatic step();
        @(posedge clk);
        cyc++;
        model_edge(0, v0, dat0);
        model_edge(1, v1, dat1);
        #1;
        cmp_dut(0, tx0, busy0, ready0, count0);
        cmp_dut(1, tx1, busy1, ready1, count1);
        if (!rst_n) begin
            rx_on = 1'b0;
        end else if (!rx_on) begin
            if (tx0 === 1'b0) begin
                rx_on = 1'b1;
                rx_t  = 0;
            end
        end else begin
            rx_t++;
            if (rx_t % CPB == CPB / 2) begin
                if (rx_t / CPB == 0) begin
                    chk($sformatf("rx_start@%0d", cyc), {31'b0, tx0}, 32'd0);
                end else if (rx_t / CPB <= 8) begin
                    rx_b[rx_t / CPB - 1] = tx0;
                end else begin
                    chk($sformatf("rx_stop@%0d", cyc), {31'b0, tx0}, 32'd1);
                    rx_q.push_back(rx_b);
                    rx_on = 1'b0;
                end
            end
        end
    endtask

    task automatic wait_idle();
        idle_ok = 1'b0;
        for (int i = 0; i < 3000; i++) begin
            if (!mbusy[0] && !mbusy[1] && msize[0] == 0 && msize[1] == 0) begin
                idle_ok = 1'b1;
                break;
            end
            step();
        end
        chk("wait_idle", {31'b0, idle_ok}, 32'd1);
    endtask

    initial begin
        frame_len[0] = 10 * CPB;
        frame_len[1] = 11 * CPB;
        msize[0] = 0; msize[1] = 0;
        mbusy[0] = 1'b0; mbusy[1] = 1'b0;
        rx_on = 1'b0; rx_t = 0; rx_b = '0;
        a5_line = 10'b1101001010;
        rst_n = 1'b0; v0 = 1'b0; v1 = 1'b0; dat0 = '0; dat1 = '0;

        // Reset state
        step();
        step();
        chk("rst_tx", {31'b0, tx0}, 32'd1);
        chk("rst_busy", {31'b0, busy0}, 32'd0);
        chk("rst_ready", {31'b0, ready0}, 32'd1);
        chk("rst_count", {29'b0, count0}, 32'd0);
        rst_n = 1'b1;
        step();

        // Single byte 0xA5
        v0 = 1'b1; dat0 = 8'hA5;
        step();
        n = cyc; v0 = 1'b0;
        chk("a5_count_push", {29'b0, count0}, 32'd1);
        step();
        chk("a5_fall", {31'b0, tx0}, 32'd0);
        chk("a5_count_pop", {29'b0, count0}, 32'd0);
        for (int k = 0; k < 10; k++) begin
            while (cyc < n + 1 + CPB * k + CPB / 2) step();
            chk($sformatf("a5_bit%0d", k), {31'b0, tx0}, {31'b0, a5_line[k]});
        end
        while (cyc < n + 80) step();
        chk("a5_busy_last", {31'b0, busy0}, 32'd1);
        step();
        chk("a5_busy_fall", {31'b0, busy0}, 32'd0);
        wait_idle();

        // Back-to-back frames
        bc = 0;
        v0 = 1'b1; dat0 = 8'h00; step(); if (busy0) bc++;
        dat0 = 8'hFF; step(); if (busy0) bc++;
        dat0 = 8'h55; step(); if (busy0) bc++;
        v0 = 1'b0;
        for (int i = 0; i < 400 && busy0; i++) begin
            step();
            if (busy0) bc++;
        end
        chk("b2b_busy_cycles", bc, 32'd240);
        wait_idle();

        // Full FIFO / backpressure
        base_sent = sent_q.size();
        saw_full = 1'b0;
        v0 = 1'b1;
        for (int i = 0; i < 8; i++) begin
            dat0 = 8'h10 + 8'(i);
            step();
            if (count0 == 3'd4 && !ready0) saw_full = 1'b1;
        end
        v0 = 1'b0;
        chk("bp_full_seen", {31'b0, saw_full}, 32'd1);
        wait_idle();
        chk("bp_accepted", sent_q.size() - base_sent, 32'd5);
        chk("bp_last_byte", {24'b0, sent_q[sent_q.size()-1]}, 32'h14);

        // Two stop bits on dut1
        v1 = 1'b1; dat1 = 8'h3C;
        step();
        dat1 = 8'($urandom);
        step();
        s = cyc; v1 = 1'b0;
        chk("ts_fall", {31'b0, tx1}, 32'd0);
        while (cyc < s + 71) step();
        chk("ts_bit7", {31'b0, tx1}, 32'd0);
        step();
        chk("ts_stop_begin", {31'b0, tx1}, 32'd1);
        while (cyc < s + 87) step();
        chk("ts_stop_end", {31'b0, tx1}, 32'd1);
        step();
        chk("ts_next_start", {31'b0, tx1}, 32'd0);
        wait_idle();

        // Push coinciding with the pop at the end of STOP
        v0 = 1'b1; dat0 = 8'($urandom);
        step();
        dat0 = 8'($urandom);
        step();
        s = cyc; v0 = 1'b0;
        chk("pp_idle_count", {29'b0, count0}, 32'd1);
        while (cyc < s + 79) step();
        v0 = 1'b1; dat0 = 8'($urandom);
        step();
        v0 = 1'b0;
        chk("pp_stop_count", {29'b0, count0}, 32'd1);
        chk("pp_restart", {31'b0, tx0}, 32'd0);
        wait_idle();

        // Randomized traffic on both instances
        for (int i = 0; i < 700; i++) begin
            v0 = ($urandom_range(3) == 0);
            v1 = ($urandom_range(3) == 0);
            dat0 = 8'($urandom);
            dat1 = 8'($urandom);
            step();
        end
        v0 = 1'b0; v1 = 1'b0;
        wait_idle();

        // Reset during data bit 3
        v0 = 1'b1; dat0 = 8'hFF;
        step();
        dat0 = 8'h81;
        step();
        s = cyc; v0 = 1'b0;
        while (cyc < s + 34) step();
        rst_n = 1'b0;
        step();
        chk("mr_tx", {31'b0, tx0}, 32'd1);
        chk("mr_busy", {31'b0, busy0}, 32'd0);
        chk("mr_count", {29'b0, count0}, 32'd0);
        chk("mr_ready", {31'b0, ready0}, 32'd1);
        rst_n = 1'b1;
        q_ok = 1'b1;
        for (int i = 0; i < 100; i++) begin
            step();
            if (tx0 !== 1'b1 || busy0 !== 1'b0) q_ok = 1'b0;
        end
        chk("mr_quiet", {31'b0, q_ok}, 32'd1);

        // Receiver decode must match every completed frame, in order
        chk("rx_frames", rx_q.size(), sent_q.size());
        for (int i = 0; i < rx_q.size() && i < sent_q.size(); i++) begin
            chk($sformatf("rx_byte%0d", i), {24'b0, rx_q[i]}, {24'b0, sent_q[i]});
        end

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
